hazard_unit_mc: RTL and testbench
=================================

HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 SHALL have parameter NSRC, default 3, meaning number of register source operands per instruction (range 1..4).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning register address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, meaning load-use stall cycles (range 1..4).
REQ-004 SHALL have parameter MUL_LAT, default 3, meaning multi-cycle multiply occupancy of E in cycles (range 2..8).
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  asynchronous active-high reset.
- RA_D  in  NSRC*ADDR_W  source addresses in Decode; slot i is bits [i*ADDR_W +: ADDR_W].
- RA_E  in  NSRC*ADDR_W  source addresses in Execute.
- WA3E, WA3M, WA3W  in  ADDR_W each  destination address in E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  destination valid.
- MemtoRegE  in  1  instruction in E is a load.
- MulStartE  in  1  instruction in E is a multi-cycle multiply.
- BranchTakenE  in  1  branch resolved taken in E.
- PCWrPendingF  in  1  PC write in flight.
- PCSrcW  in  1  PC written in W.
- ForwardE  out  2*NSRC  per-slot mux select: 00 register file, 01 W result, 10 M result.
- StallF, StallD, StallE  out  1 each  hold stage register.
- FlushD, FlushE  out  1 each  clear stage register.
- MulBusy  out  1  multiply occupying E.

Function
REQ-006 SHALL treat address all-ones (PC) as never matching: no forward, no load stall.
REQ-007 SHALL set ForwardE slot i to 10 when RA_E[i]==WA3M and RegWriteM; otherwise to 01 when RA_E[i]==WA3W and RegWriteW; otherwise to 00. M has priority.
REQ-008 SHALL detect lduse = MemtoRegE & RegWriteE & (any slot RA_D[i]==WA3E) & !BranchTakenE & !MulBusy.
REQ-009 SHALL hold 3-bit ld_cnt; when ld_cnt==0 and lduse, SHALL load ld_cnt to LOAD_LAT-1; when ld_cnt!=0, SHALL decrement it each cycle.
REQ-010 SHALL define ldstall = lduse | (ld_cnt!=0); total stall length is exactly LOAD_LAT cycles.
REQ-011 SHALL hold 4-bit mul_cnt; when mul_cnt==0 and MulStartE, SHALL load MUL_LAT-1; when nonzero, SHALL decrement it.
REQ-012 SHALL assert MulBusy = (mul_cnt!=0); MulStartE while busy SHALL be ignored.
REQ-013 SHALL assign StallE = MulBusy.
REQ-014 SHALL assign StallD = ldstall | MulBusy.
REQ-015 SHALL assign StallF = ldstall | MulBusy | PCWrPendingF.
REQ-016 SHALL assign FlushE = (ldstall | BranchTakenE) & !MulBusy.
REQ-017 SHALL assign FlushD = (PCWrPendingF | PCSrcW | BranchTakenE) & !MulBusy.
REQ-018 BranchTakenE while MulBusy SHALL be ignored; the instruction in E is the multiply.
REQ-019 BranchTakenE during an active ld_cnt SHALL clear ld_cnt to 0 on the next edge, because the wrong path is squashed.
REQ-020 All outputs SHALL be combinational from inputs and the two counters; there is no other state.

Reset
REQ-021 sys_rst SHALL clear ld_cnt and mul_cnt asynchronously, including mid-stall.
REQ-022 During reset, outputs SHALL be: ForwardE 0, Stall* 0, MulBusy 0; FlushD/FlushE follow their inputs only.

Structure
REQ-023 Package hazard_pkg SHALL hold FWD_RF/FWD_W/FWD_M encodings, the PC address constant and counter widths.
REQ-024 Sub-module hazard_match SHALL hold one slot's comparators plus forward priority, and SHALL be instantiated NSRC times by generate.

Verification
REQ-025 The bench SHALL cover these directed scenarios.
- Slot 2 RA_E=5, WA3M=5, RegWriteM=1, WA3W=5, RegWriteW=1 -> ForwardE[5:4]=10.
- LOAD_LAT=3, load to r4 in E, RA_D slot0=4 -> StallF/StallD high exactly 3 cycles, FlushE high 3 cycles, then release.
- RA_D=15 matching load WA3E=15 -> no stall; RA_E=15=WA3M -> ForwardE=00.
- MUL_LAT=3, MulStartE pulse -> MulBusy/StallE/StallD/StallF high 2 cycles, FlushE low, second MulStartE ignored.
- Load-use with BranchTakenE same cycle -> StallD=0, FlushE=1, FlushD=1.
- sys_rst asserted with ld_cnt=2 -> stalls drop immediately; after release, idle.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the multi-cycle hazard unit.
//   FWD_RF / FWD_W / FWD_M : ForwardE slot encodings (register file, W result, M result)
//   PC_ADDR                : all-ones register address (the PC); callers slice it to ADDR_W
//   LD_CNT_W / MUL_CNT_W   : widths of the load-use and multiply occupancy counters
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Wide enough for any practical ADDR_W; the low ADDR_W bits are all ones.
    localparam logic [31:0] PC_ADDR = 32'hFFFF_FFFF;

    localparam int LD_CNT_W  = 3;
    localparam int MUL_CNT_W = 4;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: pipeline <-> hazard unit signal bundle.
//   master : pipeline side, drives register addresses, valids and control events,
//            receives forward selects, stalls, flushes and MulBusy
//   slave  : hazard unit side (mirror of master)
//   RA_D / RA_E pack NSRC source addresses; slot i is bits [i*ADDR_W +: ADDR_W].
interface hazard_unit_mc_if #(
    parameter int NSRC   = 3,
    parameter int ADDR_W = 4
);

    logic [NSRC*ADDR_W-1:0] RA_D;
    logic [NSRC*ADDR_W-1:0] RA_E;
    logic [ADDR_W-1:0]      WA3E;
    logic [ADDR_W-1:0]      WA3M;
    logic [ADDR_W-1:0]      WA3W;
    logic                   RegWriteE;
    logic                   RegWriteM;
    logic                   RegWriteW;
    logic                   MemtoRegE;
    logic                   MulStartE;
    logic                   BranchTakenE;
    logic                   PCWrPendingF;
    logic                   PCSrcW;
    logic [2*NSRC-1:0]      ForwardE;
    logic                   StallF;
    logic                   StallD;
    logic                   StallE;
    logic                   FlushD;
    logic                   FlushE;
    logic                   MulBusy;

    modport master (
        output RA_D, RA_E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW,
        output MemtoRegE, MulStartE, BranchTakenE, PCWrPendingF, PCSrcW,
        input  ForwardE, StallF, StallD, StallE, FlushD, FlushE, MulBusy
    );

    modport slave (
        input  RA_D, RA_E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  MemtoRegE, MulStartE, BranchTakenE, PCWrPendingF, PCSrcW,
        output ForwardE, StallF, StallD, StallE, FlushD, FlushE, MulBusy
    );

endinterface

// File: rtl/hazard_match.sv
// hazard_match: comparators for one source-operand slot.
//   raD, raE           : this slot's source address in Decode / Execute
//   wa3E, wa3M, wa3W   : destination addresses in E, M, W
//   regWriteM/W        : destination valids for M and W
//   fwd                : forward select for the slot (M beats W beats register file)
//   matchD             : Decode source equals E destination (load-use candidate)
// The PC address never matches, so reads of the PC neither forward nor stall.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] raD,
    input  logic [ADDR_W-1:0] raE,
    input  logic [ADDR_W-1:0] wa3E,
    input  logic [ADDR_W-1:0] wa3M,
    input  logic [ADDR_W-1:0] wa3W,
    input  logic              regWriteM,
    input  logic              regWriteW,
    output logic [1:0]        fwd,
    output logic              matchD
);

    logic [ADDR_W-1:0] pcAddr;
    logic              hitM;
    logic              hitW;

    assign pcAddr = PC_ADDR[ADDR_W-1:0];
    assign hitM   = regWriteM && (raE == wa3M) && (raE != pcAddr);
    assign hitW   = regWriteW && (raE == wa3W) && (raE != pcAddr);
    assign fwd    = hitM ? FWD_M : hitW ? FWD_W : FWD_RF;
    assign matchD = (raD == wa3E) && (raD != pcAddr);

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use stall and multi-cycle multiply hazard unit.
//   sys_clk, sys_rst : clock (rising edge) and asynchronous active-high reset
//   bus (slave)      : addresses/valids/events in; ForwardE, StallF/D/E, FlushD/E, MulBusy out
// State is two counters: ldCnt extends a load-use stall to LOAD_LAT cycles, mulCnt
// keeps E occupied for MUL_LAT cycles after a multiply starts. Everything else is
// combinational. While the multiply holds E, the instruction in E is the multiply,
// so load-use detection and taken branches are ignored.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int NSRC     = 3,
    parameter int ADDR_W   = 4,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    hazard_unit_mc_if.slave    bus
);

    logic [LD_CNT_W-1:0]  ldCnt;
    logic [MUL_CNT_W-1:0] mulCnt;
    logic [NSRC-1:0]      matchD;
    logic [2*NSRC-1:0]    fwd;
    logic                 mulBusy;
    logic                 ldUse;
    logic                 ldStall;
    logic                 branchLive;

    genvar i;
    for (i = 0; i < NSRC; i++) begin : gSlot
        hazard_match #(.ADDR_W(ADDR_W)) uMatch (
            .raD       (bus.RA_D[i*ADDR_W +: ADDR_W]),
            .raE       (bus.RA_E[i*ADDR_W +: ADDR_W]),
            .wa3E      (bus.WA3E),
            .wa3M      (bus.WA3M),
            .wa3W      (bus.WA3W),
            .regWriteM (bus.RegWriteM),
            .regWriteW (bus.RegWriteW),
            .fwd       (fwd[2*i +: 2]),
            .matchD    (matchD[i])
        );
    end

    // Reset gating keeps outputs quiet while sys_rst is high, before and after
    // the counters have cleared.
    assign mulBusy    = !sys_rst && (mulCnt != '0);
    assign branchLive = bus.BranchTakenE && !mulBusy;
    assign ldUse      = bus.MemtoRegE && bus.RegWriteE && (|matchD) && !bus.BranchTakenE && !mulBusy;
    assign ldStall    = !sys_rst && (ldUse || (ldCnt != '0));

    assign bus.ForwardE = sys_rst ? '0 : fwd;
    assign bus.MulBusy  = mulBusy;
    assign bus.StallE   = mulBusy;
    assign bus.StallD   = ldStall || mulBusy;
    assign bus.StallF   = !sys_rst && (ldStall || mulBusy || bus.PCWrPendingF);
    assign bus.FlushE   = (ldStall || bus.BranchTakenE) && !mulBusy;
    assign bus.FlushD   = (bus.PCWrPendingF || bus.PCSrcW || bus.BranchTakenE) && !mulBusy;

    // A taken branch squashes the wrong path, so a stall already in progress is dropped.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ldCnt  <= '0;
            mulCnt <= '0;
        end else begin
            ldCnt  <= (ldCnt != '0) ? (branchLive ? '0 : ldCnt - 1'b1)
                                    : (ldUse ? LD_CNT_W'(LOAD_LAT - 1) : '0);
            mulCnt <= (mulCnt != '0) ? mulCnt - 1'b1
                                     : (bus.MulStartE ? MUL_CNT_W'(MUL_LAT - 1) : '0);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed self-checking bench for hazard_unit_mc (LOAD_LAT=3, MUL_LAT=3).
module tb_hazard_unit_mc;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   asserts = 0;
    int   fails   = 0;

    always #5 sys_clk = ~sys_clk;

    hazard_unit_mc_if #(.NSRC(3), .ADDR_W(4)) hif ();

    hazard_unit_mc #(.NSRC(3), .ADDR_W(4), .LOAD_LAT(3), .MUL_LAT(3)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (hif.slave)
    );

    // {StallF, StallD, StallE, FlushD, FlushE, MulBusy}
    logic [5:0] ctl;
    assign ctl = {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE, hif.MulBusy};

    task automatic clear_inputs;
        hif.RA_D = '0; hif.RA_E = '0;
        hif.WA3E = '0; hif.WA3M = '0; hif.WA3W = '0;
        hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.MemtoRegE = 0; hif.MulStartE = 0; hif.BranchTakenE = 0;
        hif.PCWrPendingF = 0; hif.PCSrcW = 0;
    endtask

    // Drive at the falling edge, sample 1 ns later, well away from the rising edge.
    task automatic cyc;
        @(negedge sys_clk);
    endtask

    task automatic load_use_r4;
        hif.RA_D = 12'h004; hif.WA3E = 4'd4;
        hif.MemtoRegE = 1; hif.RegWriteE = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        hif.RA_E = 12'h005; hif.WA3M = 4'd5; hif.RegWriteM = 1;
        hif.PCWrPendingF = 1; hif.BranchTakenE = 1;
        #1;
        asserts++;
        if (hif.ForwardE !== 6'b000000) begin fails++; $display("FAIL reset_fwd got %b want 000000", hif.ForwardE); end
        asserts++;
        if (ctl !== 6'b000110) begin fails++; $display("FAIL reset_ctl got %b want 000110", ctl); end
        cyc(); sys_rst = 0; clear_inputs(); #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL reset_idle got %b want 000000", ctl); end
    endtask

    task automatic test_forward;
        logic [5:0] exp [4] = '{6'b10_00_00, 6'b01_00_00, 6'b00_10_01, 6'b00_00_00};
        logic       rwm [4] = '{1, 0, 1, 0};
        logic       rww [4] = '{1, 1, 1, 0};
        logic [3:0] wm  [4] = '{5, 5, 3, 3};
        logic [3:0] ww  [4] = '{5, 5, 7, 7};
        for (int k = 0; k < 4; k++) begin
            cyc(); clear_inputs();
            hif.RA_E = 12'h537;
            hif.WA3M = wm[k]; hif.RegWriteM = rwm[k];
            hif.WA3W = ww[k]; hif.RegWriteW = rww[k];
            #1;
            asserts++;
            if (hif.ForwardE !== exp[k]) begin fails++; $display("FAIL forward_%0d got %b want %b", k, hif.ForwardE, exp[k]); end
        end
    endtask

    task automatic test_pc;
        cyc(); clear_inputs();
        hif.RA_D = 12'h00F; hif.WA3E = 4'hF; hif.MemtoRegE = 1; hif.RegWriteE = 1;
        hif.RA_E = 12'h00F; hif.WA3M = 4'hF; hif.RegWriteM = 1; hif.WA3W = 4'hF; hif.RegWriteW = 1;
        #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL pc_nostall got %b want 000000", ctl); end
        asserts++;
        if (hif.ForwardE !== 6'b000000) begin fails++; $display("FAIL pc_nofwd got %b want 000000", hif.ForwardE); end
        cyc(); #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL pc_nocount got %b want 000000", ctl); end
    endtask

    task automatic test_load_use;
        cyc(); clear_inputs(); load_use_r4();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) hif.MemtoRegE = 0;
            #1;
            asserts++;
            if (ctl !== (k < 3 ? 6'b110010 : 6'b000000)) begin
                fails++; $display("FAIL load_use_cyc%0d got %b want %b", k, ctl, (k < 3 ? 6'b110010 : 6'b000000));
            end
            cyc();
        end
    endtask

    task automatic test_mul;
        cyc(); clear_inputs(); hif.MulStartE = 1; #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL mul_start got %b want 000000", ctl); end
        cyc(); hif.BranchTakenE = 1; #1;
        asserts++;
        if (ctl !== 6'b111001) begin fails++; $display("FAIL mul_busy1 got %b want 111001", ctl); end
        cyc(); hif.MulStartE = 0; hif.BranchTakenE = 0; #1;
        asserts++;
        if (ctl !== 6'b111001) begin fails++; $display("FAIL mul_busy2 got %b want 111001", ctl); end
        cyc(); #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL mul_release got %b want 000000", ctl); end
    endtask

    task automatic test_branch;
        cyc(); clear_inputs(); load_use_r4(); hif.BranchTakenE = 1; #1;
        asserts++;
        if (ctl !== 6'b000110) begin fails++; $display("FAIL branch_lduse got %b want 000110", ctl); end
        cyc(); clear_inputs(); #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL branch_nocount got %b want 000000", ctl); end
        cyc(); load_use_r4(); #1;
        cyc(); hif.MemtoRegE = 0; hif.BranchTakenE = 1; #1;
        asserts++;
        if (ctl !== 6'b110110) begin fails++; $display("FAIL branch_midstall got %b want 110110", ctl); end
        cyc(); hif.BranchTakenE = 0; #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL branch_squash got %b want 000000", ctl); end
    endtask

    task automatic test_reset_mid;
        cyc(); clear_inputs(); load_use_r4(); #1;
        cyc(); hif.MemtoRegE = 0; #1;
        asserts++;
        if (ctl !== 6'b110010) begin fails++; $display("FAIL rstmid_pre got %b want 110010", ctl); end
        sys_rst = 1; #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL rstmid_during got %b want 000000", ctl); end
        sys_rst = 0; #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL rstmid_after got %b want 000000", ctl); end
        cyc(); clear_inputs(); #1;
        asserts++;
        if (ctl !== 6'b000000) begin fails++; $display("FAIL rstmid_idle got %b want 000000", ctl); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_pc();
        test_load_use();
        test_mul();
        test_branch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
